// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: first-word-fall-through FIFO for the UART RX/TX data paths.
// Provides an occupancy count, programmable almost-full and almost-empty flags,
// a synchronous flush, and sticky overflow/underflow error flags.
// A read and a write in the same cycle are handled correctly when the FIFO is full or empty.
module uart_fifo_ctrl #(
    parameter int B     = 8,   // data word width
    parameter int W     = 4,   // address bits, depth = 2**W
    parameter int AF_TH = 12,  // almost_full when count >= AF_TH
    parameter int AE_TH = 2    // almost_empty when count <= AE_TH
) (
    input  logic         clk,
    input  logic         reset,        // synchronous, active-low
    input  logic         flush,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam int         DEPTH   = 2 ** W;
    localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
    localparam logic [W:0] AF_C    = (W+1)'(AF_TH);
    localparam logic [W:0] AE_C    = (W+1)'(AE_TH);

    // Storage array; contents survive reset and flush, so it has no reset.
    logic [B-1:0] mem [DEPTH];

    logic [W-1:0] w_ptr_reg, w_ptr_next;
    logic [W-1:0] r_ptr_reg, r_ptr_next;
    logic [W:0]   count_reg, count_next;
    logic         full_reg, full_next;
    logic         empty_reg, empty_next;
    logic         af_reg, af_next;
    logic         ae_reg, ae_next;
    logic         ovf_reg, ovf_next;
    logic         unf_reg, unf_next;
    logic         pop_ok, push_ok, wr_en;

    // Accept/reject decisions, pointer and count updates, and flags derived from the next count.
    always_comb begin
        pop_ok     = rd & ~empty_reg;
        // A full FIFO still takes a push when a pop frees a slot in the same cycle.
        push_ok    = wr & (~full_reg | pop_ok);
        w_ptr_next = w_ptr_reg;
        r_ptr_next = r_ptr_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        wr_en      = 1'b0;

        if (flush) begin
            // A flush ignores rd/wr and leaves the sticky error flags as they are.
            w_ptr_next = '0;
            r_ptr_next = '0;
            count_next = '0;
        end else begin
            wr_en = push_ok;
            if (push_ok)
                w_ptr_next = w_ptr_reg + W'(1);
            if (pop_ok)
                r_ptr_next = r_ptr_reg + W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + (W+1)'(1);
                2'b01:   count_next = count_reg - (W+1)'(1);
                default: count_next = count_reg;
            endcase
            // A clear and a new error in the same cycle: the new error wins.
            if (clr_err) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end
            if (wr & ~push_ok)
                ovf_next = 1'b1;
            if (rd & ~pop_ok)
                unf_next = 1'b1;
        end

        full_next  = (count_next == DEPTH_C);
        empty_next = (count_next == '0);
        af_next    = (count_next >= AF_C);
        ae_next    = (count_next <= AE_C);
    end

    // State register; reset has priority over flush and every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            w_ptr_reg <= w_ptr_next;
            r_ptr_reg <= r_ptr_next;
            count_reg <= count_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
            af_reg    <= af_next;
            ae_reg    <= ae_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Word write on an accepted push; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && wr_en)
            mem[w_ptr_reg] <= w_data;
    end

    // The head word falls through combinationally from the registered read pointer.
    assign r_data       = mem[r_ptr_reg];
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign count        = count_reg;
    assign overflow     = ovf_reg;
    assign underflow    = unf_reg;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed and random stimulus for uart_fifo_ctrl.
// Expected values come from a queue-based reference model of the FIFO behaviour.
module tb_uart_fifo_ctrl;

    localparam int B     = 8;
    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;
    logic         clr_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [B-1:0] q[$];
    logic         m_ovf;
    logic         m_unf;

    uart_fifo_ctrl #(.B(B), .W(W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs (called at a falling edge), advance the model,
    // then compare every output at the next falling edge.
    task automatic step(input logic rst_n, input logic fl, input logic w, input logic [B-1:0] wd,
                        input logic r, input logic ce);
        bit m_empty, m_full, p_ok, w_ok;
        int n;
        reset   = rst_n;
        flush   = fl;
        wr      = w;
        w_data  = wd;
        rd      = r;
        clr_err = ce;

        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            m_empty = (q.size() == 0);
            m_full  = (q.size() == DEPTH);
            p_ok    = r && !m_empty;
            w_ok    = w && (!m_full || p_ok);
            if (ce) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (w && !w_ok) m_ovf = 1'b1;
            if (r && !p_ok) m_unf = 1'b1;
            if (p_ok) void'(q.pop_front());
            if (w_ok) q.push_back(wd);
        end

        @(posedge clk);
        @(negedge clk);

        n = q.size();
        $display("txn rst=%0b fl=%0b wr=%0b wd=%02h rd=%0b ce=%0b -> count=%0d r_data=%02h ovf=%0b unf=%0b",
                 rst_n, fl, w, wd, r, ce, count, r_data, overflow, underflow);
        check("count",        32'(count),        32'(n));
        check("empty",        32'(empty),        32'(n == 0));
        check("full",         32'(full),         32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= AF_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
        if (n > 0)
            check("r_data", 32'(r_data), 32'(q[0]));
    endtask

    initial begin
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        reset   = 1'b0;
        flush   = 1'b0;
        wr      = 1'b0;
        w_data  = '0;
        rd      = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);

        // 1. Fill to full
        step(1, 0, 1, 8'hA1, 0, 0);
        step(1, 0, 1, 8'hA2, 0, 0);
        step(1, 0, 1, 8'hA3, 0, 0);
        step(1, 0, 1, 8'hA4, 0, 0);

        // 2. Push rejected when full, then drain in order
        step(1, 0, 1, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 1, 0);

        // 3. Simultaneous push/pop while full
        step(1, 0, 0, 8'h00, 0, 1);
        step(1, 0, 1, 8'hA1, 0, 0);
        step(1, 0, 1, 8'hA2, 0, 0);
        step(1, 0, 1, 8'hA3, 0, 0);
        step(1, 0, 1, 8'hA4, 0, 0);
        step(1, 0, 1, 8'hB5, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 1, 0);

        // 4. Simultaneous push/pop while empty, then clear errors
        step(1, 0, 1, 8'hC7, 1, 0);
        step(1, 0, 0, 8'h00, 0, 1);
        step(1, 0, 0, 8'h00, 1, 0);

        // 5. Pointer wrap with push/pop pairs
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 8'(i), 0, 0);
            step(1, 0, 0, 8'h00, 1, 0);
        end

        // 6. Flush at count 3 with rd/wr asserted, then reset mid-stream
        step(1, 0, 1, 8'h11, 0, 0);
        step(1, 0, 1, 8'h22, 0, 0);
        step(1, 0, 1, 8'h33, 0, 0);
        step(1, 1, 1, 8'h44, 1, 0);
        step(1, 0, 1, 8'h55, 0, 0);
        step(1, 0, 1, 8'h66, 0, 0);
        step(1, 0, 1, 8'h77, 1, 0);
        step(1, 0, 0, 8'h00, 1, 0);
        step(1, 0, 0, 8'h00, 1, 0);
        step(1, 0, 0, 8'h00, 1, 0);  // underflow
        step(1, 0, 1, 8'h88, 0, 0);
        step(0, 0, 1, 8'h99, 1, 0);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
